fpmul_arbiter: RTL and testbench
================================

# fpmul_arbiter

Round-robin arbiter that shares one multi-cycle floating-point multiplier (`fpmul`, start/ready handshake) among `NREQ` requesters. It accepts one operand pair at a time and holds the operands stable on the multiplier inputs for the whole operation. It pulses `start`, waits for `ready`, captures the product and returns it to the granted requester through a valid/ready response channel. It sits between the core's FP issue ports and the single shared `fpmul` instance.

## Interface

Parameters:
- `N_BIT`, 32: operand/result width; must match the `fpmul` instance.
- `NREQ`, 4: number of requesters, ≥2.
- `IDX_BIT`, `$clog2(NREQ)`: requester index width (derived).
- `CNT_BIT`, 32: completed-operation counter width.

Ports:
- `clk`: in, 1. Single clock; all state on rising edge.
- `rst_n`: in, 1. Reset, asynchronous and active-low.
- `req_valid`: in, NREQ. Bit i: requester i presents an operand pair.
- `req_ready`: out, NREQ. Bit i: pair accepted this cycle. One-hot or zero.
- `req_a`, `req_b`: in, NREQ*N_BIT. Flattened operands; slice i is `[i*N_BIT +: N_BIT]`.
- `resp_valid`: out, NREQ. Bit i: `resp_data` belongs to requester i. One-hot or zero.
- `resp_ready`: in, NREQ. Bit i: requester i takes the response.
- `resp_data`: out, N_BIT. Captured product.
- `mul_a`, `mul_b`: out, N_BIT. To `fpmul` `a`/`b`.
- `mul_start`: out, 1. To `fpmul` `start`; one-cycle pulse.
- `mul_ready`: in, 1. From `fpmul` `ready`.
- `mul_out`: in, N_BIT. From `fpmul` `out`.
- `busy`: out, 1. High in every state except IDLE.
- `grant_idx`: out, IDX_BIT. Index of the current owner; valid while `busy`.
- `op_count`: out, CNT_BIT. Number of completed response handshakes.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The winner is the first i with `req_valid[i]`, scanning `rr_ptr, rr_ptr+1, … mod NREQ`.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On the edge: latch `req_a`/`req_b` slices into the operand registers, latch `grant_idx`, go to ISSUE.
  - If no `req_valid`, stay in IDLE.
- **ISSUE**: `mul_start=1` for exactly this cycle. Next state is WAIT.
- **WAIT**
  - `mul_start=0`.
  - When `mul_ready` is sampled 1, capture `mul_out` into `resp_data` and go to RESP.
- **RESP**
  - `resp_valid[grant_idx]=1`.
  - When `resp_ready[grant_idx]`:
    - `op_count` increments, wrapping modulo 2^CNT_BIT.
    - `rr_ptr` becomes `grant_idx+1`, wrapping from NREQ-1 to 0.
    - Next state is IDLE.
  - `resp_ready` bits of other requesters are ignored.
- `mul_a`/`mul_b` are driven from the operand registers at all times. They change only on an IDLE acceptance edge, because `fpmul` evaluates its exponent and special-case logic combinationally from `a`/`b` while its mantissa product is in flight.
- `req_ready` is 0 in ISSUE, WAIT and RESP. There is one operation in flight at most.
- A requester may deassert `req_valid` at any time before acceptance. After acceptance, the request cannot be cancelled.
- `resp_data`, `grant_idx` and the operand registers hold their values until the next acceptance.
- Multiplier contract: `mul_ready` is low from the cycle after `start` until the result is valid. The arbiter ignores `mul_ready` in the IDLE and ISSUE states.

## Timing

- Reset (`rst_n` low, asynchronous):
  - state=IDLE, `rr_ptr`=0, `grant_idx`=0.
  - Operand registers=0, `resp_data`=0, `op_count`=0.
  - `mul_start`=0, `resp_valid`=0, `busy`=0.
  - `req_ready` follows IDLE arbitration once `rst_n` is high.
- Reset during ISSUE, WAIT or RESP aborts the operation and drops the response. The multiplier's later `ready` is ignored because the arbiter is in IDLE.
- Accept at edge T (IDLE). ISSUE in cycle T+1 with `mul_start=1`. WAIT from T+2.
- If `mul_ready` is first high in cycle T+1+L, `resp_valid` rises in cycle T+2+L.
- With `resp_ready` held high, the response handshake completes in that same cycle and IDLE is in cycle T+3+L. The next acceptance can then occur in cycle T+3+L.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
  - No requester waits more than NREQ-1 operations.
- Simultaneous `req_valid` and `resp_ready` in RESP: the request is not accepted until IDLE.
- `op_count` updates on the handshake edge.

## Test plan

- **Single request, latency.** After reset, raise `req_valid[2]` with `req_a=32'h3FC00000` (1.5) and `req_b=32'h40000000` (2.0); `fpmul` model `ready` after L=5.
  - `req_ready=4'b0100` in the same cycle.
  - `mul_start` pulses for one cycle.
  - `resp_valid=4'b0100` with `resp_data=32'h40400000` (3.0) exactly L+1 cycles after the start cycle.
  - `op_count=1`.
- **Round-robin.** Hold all four `req_valid` high and `resp_ready` high.
  - Grant order is 0,1,2,3,0,1.
  - After six operations, `op_count=6`.
- **Operand stability.** Change `req_a`/`req_b` of every requester on every cycle during WAIT.
  - `mul_a`/`mul_b` remain the captured values until `resp_valid`.
  - The captured values are never the changed ones.
- **Response backpressure.** Hold `resp_ready[1]=0` for 10 cycles after `resp_valid[1]`, with `resp_ready` of the other requesters high.
  - `resp_valid` and `resp_data` stay stable.
  - `req_ready` stays 0.
  - The state leaves RESP only on `resp_ready[1]`.
- **Stale `ready` and reset mid-op.**
  - Model `ready` is stuck high while idle: no capture occurs before WAIT.
  - Assert `rst_n=0` asynchronously mid-WAIT: `busy` and `resp_valid` go to 0 immediately, `op_count=0`, and a later model `ready` produces no response.
- **Counter wrap.** With CNT_BIT=4, complete 17 operations: `op_count=1`.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fpmul (start/ready) among NREQ requesters.
// One operation in flight; operands held on mul_a/mul_b until the next acceptance.
module fpmul_arbiter #(
   parameter int N_BIT   = 32,
   parameter int NREQ    = 4,
   parameter int IDX_BIT = $clog2(NREQ),
   parameter int CNT_BIT = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*N_BIT-1:0]   req_a,
   input  logic [NREQ*N_BIT-1:0]   req_b,
   output logic [NREQ-1:0]         resp_valid,
   input  logic [NREQ-1:0]         resp_ready,
   output logic [N_BIT-1:0]        resp_data,
   output logic [N_BIT-1:0]        mul_a,
   output logic [N_BIT-1:0]        mul_b,
   output logic                    mul_start,
   input  logic                    mul_ready,
   input  logic [N_BIT-1:0]        mul_out,
   output logic                    busy,
   output logic [IDX_BIT-1:0]      grant_idx,
   output logic [CNT_BIT-1:0]      op_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]         state;
   logic [IDX_BIT-1:0] rr_ptr;
   logic [N_BIT-1:0]   op_a;
   logic [N_BIT-1:0]   op_b;
   logic               found;
   logic [IDX_BIT-1:0] winner;
   logic [IDX_BIT:0]   scan;

   // Scan rr_ptr, rr_ptr+1, ... mod NREQ; the first valid requester wins.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      scan   = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_ptr} + (IDX_BIT+1)'(k);
         if (scan >= (IDX_BIT+1)'(NREQ))
            scan = scan - (IDX_BIT+1)'(NREQ);
         if (!found && req_valid[scan[IDX_BIT-1:0]]) begin
            found  = 1'b1;
            winner = scan[IDX_BIT-1:0];
         end
      end
   end

   assign req_ready  = (state == S_IDLE && found) ? (NREQ'(1) << winner) : '0;
   assign resp_valid = (state == S_RESP) ? (NREQ'(1) << grant_idx) : '0;
   assign mul_start  = (state == S_ISSUE);
   assign busy       = (state != S_IDLE);
   assign mul_a      = op_a;
   assign mul_b      = op_b;

   // NOTE: state uses non-blocking assignments; the operand and result registers are
   // plain flops (not a memory), so they take the asynchronous reset like everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         grant_idx <= '0;
         op_a      <= '0;
         op_b      <= '0;
         resp_data <= '0;
         op_count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  op_a      <= req_a[winner*N_BIT +: N_BIT];
                  op_b      <= req_b[winner*N_BIT +: N_BIT];
                  grant_idx <= winner;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            // mul_ready is only trusted here; stale highs in IDLE/ISSUE are ignored.
            S_WAIT: begin
               if (mul_ready) begin
                  resp_data <= mul_out;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready[grant_idx]) begin
                  op_count <= op_count + 1'b1;
                  rr_ptr   <= (grant_idx == IDX_BIT'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: behavioural fpmul model, vector table,
// randomized ops against a round-robin reference, reset-abort and counter-wrap cases.
module tb_fpmul_arbiter;

   localparam int N_BIT = 32;
   localparam int NREQ  = 4;
   localparam int IDX   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*N_BIT-1:0] req_a = '0;
   logic [NREQ*N_BIT-1:0] req_b = '0;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready = '1;
   logic [N_BIT-1:0]      resp_data;
   logic [N_BIT-1:0]      mul_a, mul_b;
   logic                  mul_start;
   logic                  m_ready = 1'b1;
   logic [N_BIT-1:0]      m_out = '0;
   logic                  busy;
   logic [IDX-1:0]        grant_idx;
   logic [31:0]           op_count;

   logic [NREQ-1:0]       req_ready4, resp_valid4;
   logic [N_BIT-1:0]      resp_data4, mul_a4, mul_b4;
   logic                  mul_start4, busy4;
   logic [IDX-1:0]        grant_idx4;
   logic [3:0]            op_count4;

   fpmul_arbiter #(.N_BIT(N_BIT), .NREQ(NREQ), .CNT_BIT(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_ready(m_ready), .mul_out(m_out), .busy(busy), .grant_idx(grant_idx),
      .op_count(op_count));

   // Narrow-counter copy sees identical stimulus; only its op_count is observed.
   fpmul_arbiter #(.N_BIT(N_BIT), .NREQ(NREQ), .CNT_BIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid4), .resp_ready(resp_ready),
      .resp_data(resp_data4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_start(mul_start4),
      .mul_ready(m_ready), .mul_out(m_out), .busy(busy4), .grant_idx(grant_idx4),
      .op_count(op_count4));

   int n_checks = 0;
   int n_errors = 0;
   int rr = 0;
   int exp_count = 0;
   int lat_cfg = 5;

   // Single-precision multiply for normal operands, truncating.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [22:0] mant;
      int e;
      p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         e++;
         mant = p[46:24];
      end else begin
         mant = p[45:23];
      end
      return {a[31] ^ b[31], 8'(e), mant};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
   endfunction

   function automatic int ref_winner(input logic [3:0] mask);
      for (int k = 0; k < NREQ; k++)
         if (mask[(rr + k) % NREQ]) return (rr + k) % NREQ;
      return -1;
   endfunction

   // Multiplier model: ready drops after start, rises lat_cfg cycles after the start cycle,
   // and otherwise stays high (stale) while idle. It ignores rst_n on purpose.
   int m_cnt = 0;
   logic [31:0] m_res = '0;
   always @(posedge clk) begin
      if (mul_start) begin
         m_cnt   <= lat_cfg - 1;
         m_ready <= 1'b0;
         m_res   <= fp_mul(mul_a, mul_b);
      end else if (m_cnt == 1) begin
         m_cnt   <= 0;
         m_ready <= 1'b1;
         m_out   <= m_res;
      end else if (m_cnt > 1) begin
         m_cnt <= m_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid  = '0;
      resp_ready = '1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_op_count", op_count, 0);
      check("rst_op_count4", op_count4, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_grant_idx", grant_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rr = 0;
      exp_count = 0;
      #1 check("rst_req_ready_idle", req_ready, 0);
   endtask

   // Starts and ends at a negedge in IDLE; the next op may be accepted on the following edge.
   task automatic run_op(input logic [3:0] mask, input int lat, input int bp, input int want,
                         input bit use_fixed, input logic [31:0] fa, input logic [31:0] fb);
      logic [31:0] av[NREQ];
      logic [31:0] bv[NREQ];
      logic [31:0] ea, eb, ep;
      int cyc;
      bit got;
      for (int i = 0; i < NREQ; i++) begin
         av[i] = rand_fp();
         bv[i] = rand_fp();
      end
      if (use_fixed) begin
         av[want] = fa;
         bv[want] = fb;
      end
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N_BIT +: N_BIT] = av[i];
         req_b[i*N_BIT +: N_BIT] = bv[i];
      end
      ea = av[want];
      eb = bv[want];
      ep = fp_mul(ea, eb);
      lat_cfg    = lat;
      req_valid  = mask;
      resp_ready = (bp > 0) ? (4'hF & ~(4'b1 << want)) : 4'hF;
      #1 check("accept_req_ready", req_ready, 4'b1 << want);

      @(negedge clk);
      req_valid = '0;
      #1;
      check("issue_mul_start", mul_start, 1);
      check("issue_busy", busy, 1);
      check("issue_grant_idx", grant_idx, want);
      check("issue_mul_a", mul_a, ea);
      check("issue_mul_b", mul_b, eb);
      check("issue_resp_valid", resp_valid, 0);

      cyc = 0;
      got = 1'b0;
      while (!got && cyc < lat + 6) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            req_a[i*N_BIT +: N_BIT] = $urandom;
            req_b[i*N_BIT +: N_BIT] = $urandom;
         end
         #1;
         if (resp_valid != '0) begin
            got = 1'b1;
         end else begin
            check("wait_mul_start", mul_start, 0);
            check("wait_mul_a_stable", mul_a, ea);
            check("wait_mul_b_stable", mul_b, eb);
         end
      end
      check("resp_latency", cyc, lat + 1);
      if (!got) return;
      check("resp_valid", resp_valid, 4'b1 << want);
      check("resp_data", resp_data, ep);
      check("resp_mul_a", mul_a, ea);
      req_valid = 4'hF;
      #1 check("resp_req_ready", req_ready, 0);

      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         #1;
         check("bp_resp_valid", resp_valid, 4'b1 << want);
         check("bp_resp_data", resp_data, ep);
         check("bp_req_ready", req_ready, 0);
         check("bp_op_count", op_count, exp_count);
      end
      resp_ready[want] = 1'b1;

      exp_count++;
      rr = (want + 1) % NREQ;
      @(negedge clk);
      #1;
      check("done_busy", busy, 0);
      check("done_resp_valid", resp_valid, 0);
      check("done_op_count", op_count, exp_count);
      check("done_op_count4", op_count4, exp_count % 16);
      check("done_resp_data_hold", resp_data, ep);
      check("done_req_ready_rr", req_ready, 4'b1 << rr);
      req_valid = '0;
   endtask

   typedef struct {
      logic [3:0] mask;
      int         lat;
      int         bp;
      int         want;
   } vec_t;

   vec_t vecs[8];
   int   rr_order[6];

   initial begin
      // Hand-derived grants, applied in order from a fresh reset (rr_ptr=0).
      vecs[0] = '{mask: 4'b0100, lat: 3, bp: 0,  want: 2};
      vecs[1] = '{mask: 4'b1111, lat: 2, bp: 0,  want: 3};
      vecs[2] = '{mask: 4'b0110, lat: 4, bp: 10, want: 1};
      vecs[3] = '{mask: 4'b0011, lat: 2, bp: 0,  want: 0};
      vecs[4] = '{mask: 4'b1000, lat: 6, bp: 2,  want: 3};
      vecs[5] = '{mask: 4'b0001, lat: 3, bp: 0,  want: 0};
      vecs[6] = '{mask: 4'b1101, lat: 2, bp: 1,  want: 2};
      vecs[7] = '{mask: 4'b0111, lat: 5, bp: 0,  want: 0};
      rr_order = '{0, 1, 2, 3, 0, 1};

      do_reset();
      // Single request: 1.5 * 2.0 = 3.0, L=5, with the model's ready stale-high beforehand.
      run_op(4'b0100, 5, 0, 2, 1'b1, 32'h3FC00000, 32'h40000000);
      check("single_resp_data", resp_data, 32'h40400000);
      check("single_op_count", op_count, 1);

      do_reset();
      for (int i = 0; i < 6; i++)
         run_op(4'hF, 2, 0, rr_order[i], 1'b0, '0, '0);
      check("rr_op_count", op_count, 6);

      do_reset();
      for (int i = 0; i < 8; i++)
         run_op(vecs[i].mask, vecs[i].lat, vecs[i].bp, vecs[i].want, 1'b0, '0, '0);

      for (int i = 0; i < 20; i++) begin
         logic [3:0] m;
         m = 4'($urandom_range(1, 15));
         run_op(m, $urandom_range(2, 6), $urandom_range(0, 3), ref_winner(m), 1'b0, '0, '0);
      end

      // Reset mid-WAIT: operation aborted, later ready from the multiplier is ignored.
      lat_cfg = 8;
      req_valid = 4'hF;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_resp_valid", resp_valid, 0);
      check("abort_op_count", op_count, 0);
      check("abort_mul_start", mul_start, 0);
      check("abort_mul_a", mul_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rr = 0;
      exp_count = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         check("abort_no_resp", resp_valid, 0);
         check("abort_idle", busy, 0);
      end
      run_op(4'hF, 3, 0, 0, 1'b0, '0, '0);

      do_reset();
      for (int i = 0; i < 17; i++) begin
         logic [3:0] m;
         m = 4'($urandom_range(1, 15));
         run_op(m, 2, 0, ref_winner(m), 1'b0, '0, '0);
      end
      check("wrap_op_count4", op_count4, 1);
      check("wrap_op_count", op_count, 17);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
